// File: rtl/tc_pkg.sv
// Shared widths and fixed-point helpers for the TrackletCalculator rescale points.
package tc_pkg;

    localparam int DEF_PROD_W = 31;
    localparam int DEF_SHIFT  = 14;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_CNT_W  = 16;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_res_t;

    // Clamp a signed value into a signed field of the given width, flagging a clip.
    function automatic sat_res_t sat_signed(input logic signed [63:0] value,
                                            input int unsigned        width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_res_t           res;
        max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (width - 1));
        res.sat = 1'b1;
        if (value > max_v) begin
            res.value = max_v;
        end else if (value < min_v) begin
            res.value = min_v;
        end else begin
            res.value = value;
            res.sat   = 1'b0;
        end
        return res;
    endfunction

    // Arithmetic right shift with round-half-toward-plus-infinity.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                       input int unsigned        shift);
        return (value + (64'sd1 <<< (shift - 1))) >>> shift;
    endfunction

endpackage

// File: rtl/tc_product_rescale_if.sv
// Product-in / rescaled-word-out stream bundle plus per-event status.
interface tc_product_rescale_if
    import tc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic signed [PROD_W-1:0] prod_data;
    logic                     prod_valid;
    logic                     prod_last;
    logic                     prod_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_sat;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;
    logic                     ev_done;
    logic [CNT_W-1:0]         ev_count;
    logic [CNT_W-1:0]         ev_sat_count;

    modport master (
        output prod_data, prod_valid, prod_last, out_ready,
        input  prod_ready, out_data, out_sat, out_last, out_valid,
               ev_done, ev_count, ev_sat_count
    );

    modport slave (
        input  prod_data, prod_valid, prod_last, out_ready,
        output prod_ready, out_data, out_sat, out_last, out_valid,
               ev_done, ev_count, ev_sat_count
    );
endinterface

// File: rtl/tc_skid_buf.sv
// Two-entry FIFO-ordered valid/ready buffer with a registered, not-full ready.
module tc_skid_buf #(
    parameter int W = 32
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);
    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         ready_q;
    logic         push;
    logic         pop;

    assign push        = in_valid_i && ready_q;
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign in_ready_o  = ready_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Ready looks at the next occupancy so it never depends on out_ready_i combinationally.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
endmodule

// File: rtl/tc_product_rescale.sv
// Rounds and saturates multiplier products to the datapath width and tallies
// per-event word and saturation counts for the event controller.
module tc_product_rescale
    import tc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic                 ap_clk,
    input logic                 ap_rst_n,
    tc_product_rescale_if.slave bus
);
    localparam int                       SUM_W   = PROD_W + 1;
    localparam logic signed [SUM_W-1:0]  HALF    = SUM_W'(64'sd1 <<< (SHIFT - 1));
    localparam logic [CNT_W-1:0]         CNT_MAX = '1;

    logic [PROD_W:0]          skid_in;
    logic [PROD_W:0]          skid_out;
    logic                     skid_valid;
    logic                     skid_ready;
    logic signed [PROD_W-1:0] skid_prod;

    logic                     s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0]  s1_sum_q, s1_sum_d;
    logic                     s1_last_q, s1_last_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]         s2_data_q, s2_data_d;
    logic                     s2_sat_q, s2_sat_d;
    logic                     s2_last_q, s2_last_d;
    sat_res_t                 s2_res;

    logic [CNT_W-1:0]         run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]         run_sat_q, run_sat_d;
    logic [CNT_W-1:0]         ev_count_q, ev_count_d;
    logic [CNT_W-1:0]         ev_sat_q, ev_sat_d;
    logic                     ev_done_q, ev_done_d;
    logic [CNT_W-1:0]         cnt_inc;
    logic [CNT_W-1:0]         sat_inc;

    logic                     s1_load;
    logic                     s2_load;
    logic                     out_xfer;

    assign skid_in = {bus.prod_last, bus.prod_data};

    tc_skid_buf #(.W(PROD_W + 1)) u_skid (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_data_i   (skid_in),
        .in_valid_i  (bus.prod_valid),
        .in_ready_o  (bus.prod_ready),
        .out_data_o  (skid_out),
        .out_valid_o (skid_valid),
        .out_ready_i (skid_ready)
    );

    assign skid_prod  = skid_out[PROD_W-1:0];
    assign out_xfer   = s2_valid_q && bus.out_ready;
    assign s2_load    = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign skid_ready = !s1_valid_q || s2_load;
    assign s1_load    = skid_valid && skid_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_last_d  = s1_last_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = SUM_W'(skid_prod) + HALF;
            s1_last_d  = skid_out[PROD_W];
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_res     = sat_signed(64'(s1_sum_q) >>> SHIFT, OUT_W);
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        s2_last_d  = s2_last_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s2_res.value[OUT_W-1:0];
            s2_sat_d   = s2_res.sat;
            s2_last_d  = s1_last_q;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    // Counts stick at all-ones so an oversized event still reads as "at least max".
    assign cnt_inc = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_W'(1);
    assign sat_inc = (s2_sat_q && run_sat_q != CNT_MAX) ? run_sat_q + CNT_W'(1) : run_sat_q;

    always_comb begin
        run_cnt_d  = run_cnt_q;
        run_sat_d  = run_sat_q;
        ev_count_d = ev_count_q;
        ev_sat_d   = ev_sat_q;
        ev_done_d  = 1'b0;
        if (out_xfer) begin
            if (s2_last_q) begin
                ev_count_d = cnt_inc;
                ev_sat_d   = sat_inc;
                ev_done_d  = 1'b1;
                run_cnt_d  = '0;
                run_sat_d  = '0;
            end else begin
                run_cnt_d = cnt_inc;
                run_sat_d = sat_inc;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            run_cnt_q  <= '0;
            run_sat_q  <= '0;
            ev_count_q <= '0;
            ev_sat_q   <= '0;
            ev_done_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            s2_last_q  <= s2_last_d;
            run_cnt_q  <= run_cnt_d;
            run_sat_q  <= run_sat_d;
            ev_count_q <= ev_count_d;
            ev_sat_q   <= ev_sat_d;
            ev_done_q  <= ev_done_d;
        end
    end

    assign bus.out_valid    = s2_valid_q;
    assign bus.out_data     = s2_data_q;
    assign bus.out_sat      = s2_sat_q;
    assign bus.out_last     = s2_last_q;
    assign bus.ev_done      = ev_done_q;
    assign bus.ev_count     = ev_count_q;
    assign bus.ev_sat_count = ev_sat_q;
endmodule
